// File: rtl/sram_pkg.sv
// Shared defaults and FSM encoding for the SRAM read arbiter.
package sram_pkg;
    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;
    localparam int RD_LAT_DEF = 2;
    localparam int CNT_W      = 3;   // holds RD_LAT-1 for RD_LAT up to 7

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; the last-served pointer moves only when a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       advance,
    output logic [1:0] win
);
    logic last_q;  // 1: requester 1 was served last

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last_q <= 1'b1;
        else if (advance) last_q <= win[1];
    end

    assign win[0] = req0 & (~req1 | last_q);
    assign win[1] = req1 & (~req0 | ~last_q);
endmodule

// File: rtl/sram_arbiter.sv
// Read-only SRAM port shared by two voice fetchers; one outstanding access at a time.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [DATA_W-1:0] SRAM_D,
    output logic              SRAM_WE,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_LB,
    output logic              SRAM_UB,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_q, sel_d;        // winner of the access in flight
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        win;
    logic              advance;

    assign advance = (state_q == ST_IDLE) & (req0 | req1);

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req0    (req0),
        .req1    (req1),
        .advance (advance),
        .win     (win)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (advance) begin
                    addr_d  = win[1] ? addr1 : addr0;
                    sel_d   = win[1];
                    gnt0_d  = win[0];
                    gnt1_d  = win[1];
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (sel_q) begin
                        rd1_d = SRAM_D;
                        rv1_d = 1'b1;
                    end else begin
                        rd0_d = SRAM_D;
                        rv0_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign rvalid0 = rv0_q;
    assign rvalid1 = rv1_q;
    assign rdata0  = rd0_q;
    assign rdata1  = rd1_q;
    assign SRAM_A  = addr_q;
    assign busy    = (state_q != ST_IDLE);

    // Read-only, both byte lanes, chip always selected.
    assign SRAM_WE = 1'b1;
    assign SRAM_CE = 1'b0;
    assign SRAM_OE = 1'b0;
    assign SRAM_LB = 1'b0;
    assign SRAM_UB = 1'b0;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a one-cycle-latency SRAM model.
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] SRAM_A;
    logic [DW-1:0] SRAM_D = '0;
    logic          SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, busy;

    int nchk = 0;
    int nerr = 0;
    logic [DW-1:0] exp_rd0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
        .SRAM_WE(SRAM_WE), .SRAM_CE(SRAM_CE), .SRAM_OE(SRAM_OE),
        .SRAM_LB(SRAM_LB), .SRAM_UB(SRAM_UB), .busy(busy)
    );

    always #10 CLK = ~CLK;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        mem = 16'hA100 | {8'h00, a[7:0]};
    endfunction

    // Synchronous SRAM: data for the address presented at one edge appears after the next.
    always @(posedge CLK) SRAM_D <= mem(SRAM_A);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_rst;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        // Reset state and constant strobes
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_a", SRAM_A, 0);
        chk("rst_gnt", {gnt0, gnt1, rvalid0, rvalid1}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        chk("strobes", {SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB}, 5'b10000);
        RST = 1'b0;

        // Single read
        req0 = 1'b1; addr0 = 18'h00005;
        tick();
        chk("single_gnt", {gnt0, gnt1}, 2'b10);
        chk("single_a", SRAM_A, 18'h5);
        chk("single_busy", busy, 1);
        req0 = 1'b0;
        tick();
        chk("single_rv_early", {rvalid0, rvalid1, gnt0}, 0);
        tick();
        chk("single_rv", {rvalid0, rvalid1}, 2'b10);
        chk("single_data", rdata0, 16'hA105);
        tick();
        chk("single_done", {rvalid0, busy}, 0);

        // Tie after reset: alternate 0,1,0,1
        pulse_rst();
        req0 = 1'b1; req1 = 1'b1; addr0 = 18'h30; addr1 = 18'h40;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tie_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("tie_a", SRAM_A, (i % 2 == 0) ? 18'h30 : 18'h40);
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
            tick();
            chk("tie_idle", {gnt0, gnt1, rvalid0, rvalid1}, 0);
            tick();
            chk("tie_rv", {rvalid0, rvalid1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("tie_data", (i % 2 == 0) ? rdata0 : rdata1,
                (i % 2 == 0) ? 16'hA130 : 16'hA140);
        end
        exp_rd0 = 16'hA130;
        tick();

        // Solo requester 1 with incrementing address
        req1 = 1'b1; addr1 = 18'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("solo_gnt", {gnt0, gnt1}, 2'b01);
            chk("solo_a", SRAM_A, 18'h10 + i);
            addr1 = addr1 + 18'd1;
            if (i == 3) req1 = 1'b0;
            tick();
            tick();
            chk("solo_rv", {rvalid0, rvalid1}, 2'b01);
            chk("solo_data", rdata1, 16'hA110 + i);
        end
        chk("solo_rd0_kept", rdata0, exp_rd0);
        tick();

        // Address change after grant
        req0 = 1'b1; addr0 = 18'h20;
        tick();
        chk("achg_gnt", gnt0, 1);
        req0 = 1'b0;
        tick();
        addr0 = 18'h21;
        chk("achg_a", SRAM_A, 18'h20);
        tick();
        chk("achg_rv", rvalid0, 1);
        chk("achg_data", rdata0, 16'hA120);
        exp_rd0 = 16'hA120;
        tick();

        // Reset mid-access
        req1 = 1'b1; addr1 = 18'h50;
        tick();
        chk("rmid_gnt", gnt1, 1);
        req1 = 1'b0;
        tick();
        RST = 1'b1;
        #1;
        chk("rmid_async", {gnt0, gnt1, rvalid0, rvalid1, busy}, 0);
        chk("rmid_async_d", {rdata0, rdata1}, 0);
        chk("rmid_async_a", SRAM_A, 0);
        tick();
        RST = 1'b0;
        tick();
        chk("rmid_norv", {rvalid0, rvalid1, busy}, 0);
        tick();
        chk("rmid_norv2", {rvalid0, rvalid1}, 0);
        req0 = 1'b1; req1 = 1'b1; addr0 = 18'h33; addr1 = 18'h44;
        tick();
        chk("rmid_tie", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        chk("rmid_tie_data", rdata0, 16'hA133);
        exp_rd0 = 16'hA133;
        tick();

        // Cancel: req0 pulsed while busy, dropped before the arbiter is free
        req1 = 1'b1; addr1 = 18'h60;
        tick();
        chk("cancel_gnt1", gnt1, 1);
        req1 = 1'b0; req0 = 1'b1; addr0 = 18'h70;
        tick();
        chk("cancel_nogrant", gnt0, 0);
        req0 = 1'b0;
        tick();
        chk("cancel_rv1", {rvalid0, rvalid1}, 2'b01);
        chk("cancel_d1", rdata1, 16'hA160);
        tick();
        chk("cancel_idle", {gnt0, busy, rvalid0}, 0);
        chk("cancel_rd0", rdata0, exp_rd0);
        chk("cancel_a", SRAM_A, 18'h60);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    always @(negedge CLK) begin
        if (gnt0 && gnt1)       begin nchk++; nerr++; $display("FAIL gnt_excl: both grants high"); end
        if (rvalid0 && rvalid1) begin nchk++; nerr++; $display("FAIL rv_excl: both rvalids high"); end
    end
endmodule
